cnt_updown_mod: RTL and testbench
=================================

Name: cnt_updown_mod

Overview:
- Second-generation general-purpose counter for timers, debouncers and baud/tick generators.
- Adds the following over the basic fixed-END up counter:
  - parametrised width
  - runtime terminal value
  - up/down direction
  - parallel load
  - built-in prescaler
  - three selectable modes: wrap, saturate, retrigger (debounce)
- Sits between control FSMs and datapaths, one instance per timed function.

Parameters:
- WIDTH, 8, counter width in bits.
- PRESC_W, 4, prescaler ratio width in bits; step rate = clk/(presc+1).

Ports:
- clk  input  1  clock; all state updates on the falling edge, consistent with the existing counter family.
- rst  input  1  synchronous, active-low reset; sampled on the clock edge.
- en  input  1  count enable; in RETRIG mode, low also clears the count.
- up  input  1  direction: 1 = up, 0 = down; ignored in RETRIG.
- mode  input  2  0 = WRAP, 1 = SAT, 2 = RETRIG, 3 = reserved (behaves as WRAP).
- end_val  input  WIDTH  terminal value, sampled every cycle.
- presc  input  PRESC_W  prescaler ratio.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load = 1.
- clr_ovf  input  1  clears the sticky ovf flag.
- cnt  output  WIDTH  current count.
- at_end  output  1  combinational: cnt == end_val.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky: a wrap or a saturation attempt has occurred.

Behaviour:
- Reset (rst = 0 at the edge):
  - cnt = 0, tc = 0, ovf = 0, prescaler count = 0.
  - Reset overrides every other input.
- Priority per edge: reset > load > mode-specific clear > step.
- Prescaler:
  - Internal count pc runs 0..presc.
  - tick = en && (pc == presc); pc then returns to 0.
  - While en = 0, pc holds, except in RETRIG mode, where pc clears.
  - presc = 0 gives tick on every enabled edge.
  - load clears pc.
- Step = tick. Without a step, cnt holds.
- load:
  - cnt = load_val, tc = 0, ovf unchanged.
  - load_val > end_val is allowed.
- WRAP mode, up step:
  - cnt < end_val: cnt + 1.
  - cnt >= end_val: cnt = 0, tc = 1, ovf = 1.
- WRAP mode, down step:
  - cnt == 0: cnt = end_val, tc = 1, ovf = 1.
  - Otherwise: cnt − 1 (including when cnt > end_val).
- SAT mode, up step:
  - cnt >= end_val: cnt = end_val, ovf = 1, tc = 0.
  - Otherwise: cnt + 1, and tc = 1 on the step that makes cnt == end_val.
- SAT mode, down step:
  - cnt == 0: cnt holds, ovf = 1.
  - Otherwise: cnt − 1, and tc = 1 on the step reaching 0.
- RETRIG mode (debounce):
  - en = 0: cnt = 0, pc = 0.
  - en = 1: counts up on each tick until cnt == end_val, then holds.
  - tc = 1 only on the step that reaches end_val; no further pulses until en drops and the count restarts.
  - ovf is never set in RETRIG.
- tc:
  - Registered; high for exactly one clk period after the causing edge.
  - 0 on any edge without a qualifying event.
- ovf:
  - Set on a qualifying event, cleared by clr_ovf.
  - If set and clear occur in the same edge, set wins.
- end_val = 0:
  - WRAP mode: every step is a wrap; cnt stays 0 and tc pulses every tick.
  - SAT mode: cnt stays 0; every up step sets ovf.
- Mode change mid-count:
  - Takes effect at the next edge.
  - cnt is not cleared, except by the RETRIG en = 0 rule.
- Arithmetic is modulo 2^WIDTH internally, but the wrap/saturate rules above prevent natural roll-over whenever end_val < 2^WIDTH − 1.
- With end_val = all ones, WRAP mode rolls to 0 via the cnt >= end_val rule.

Decomposition:
- Package cnt_pkg:
  - Mode constants MODE_WRAP = 2'd0, MODE_SAT = 2'd1, MODE_RETRIG = 2'd2.
  - Default WIDTH/PRESC_W constants.
- One sub-module, cnt_prescaler, holding pc and generating tick. Its inputs are en, presc, a clear (load or RETRIG idle), clk and rst.
- Top level holds cnt, tc, ovf and the mode logic.

Test Plan:
1. Reset and basic wrap:
   - Stimulus: rst = 0 for 2 edges, then WRAP, up = 1, en = 1, presc = 0, end_val = 5, for 7 edges.
   - Response: cnt sequence 1, 2, 3, 4, 5, 0, 1; tc high only after the 5→0 edge; ovf = 1.
2. Down wrap with prescaler:
   - Stimulus: WRAP, up = 0, presc = 2, end_val = 9, load_val = 1 loaded, en = 1.
   - Response: cnt goes 1→0 after 3 edges and 0→9 after 3 more; tc pulses once at 0→9.
3. Saturate:
   - Stimulus: SAT, up = 1, end_val = 3, from 0.
   - Response: cnt 1, 2, 3, 3, 3; tc only at 2→3; ovf rises on the first held edge.
   - Then apply clr_ovf together with another saturating step: ovf remains 1.
4. RETRIG debounce:
   - Stimulus: end_val = 4, en high for 3 edges, low for 1, then high for 6.
   - Response: cnt 1, 2, 3, 0, 1, 2, 3, 4, 4, 4; a single tc at 3→4; ovf stays 0.
5. Load and priority:
   - Stimulus: load = 1 with load_val = 200 and end_val = 10, WRAP up, simultaneous step.
   - Response: cnt = 200 with no tc; next step gives cnt = 0, tc = 1.
   - Then rst = 0 together with load = 1: cnt = 0.
6. end_val = 0 edge case:
   - Stimulus: WRAP, up = 1, presc = 0, 4 enabled edges.
   - Response: cnt stays 0 and tc is high on each of the 4 edges.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants for the up/down counter family: mode encodings and default sizes.
package cnt_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 4;

    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_SAT    = 2'd1;
    localparam logic [1:0] MODE_RETRIG = 2'd2;

    // Mode 3 is reserved and folds onto WRAP, so only RETRIG needs a dedicated test.
    function automatic logic is_retrig(input logic [1:0] mode);
        return mode == MODE_RETRIG;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Prescaler for the counter: pc runs 0..presc while enabled and ticks on the last count.
module cnt_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pc;

    assign tick = en && (pc == presc);

    // The counter family updates on the falling edge; pc holds while en is low.
    always_ff @(negedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (clear) begin
            pc <= '0;
        end else if (en) begin
            if (tick) begin
                pc <= '0;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_updown_mod.sv
// General-purpose up/down counter with runtime terminal value, prescaler, parallel load
// and WRAP / SAT / RETRIG modes; updates on the falling edge of clk.
module cnt_updown_mod
    import cnt_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   end_val,
    input  logic [PRESC_W-1:0] presc,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               clr_ovf,
    output logic [WIDTH-1:0]   cnt,
    output logic               at_end,
    output logic               tc,
    output logic               ovf
);

    logic             tick;
    logic             retrig_idle;
    logic             presc_clear;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             ovf_set;

    assign retrig_idle = is_retrig(mode) && !en;
    assign presc_clear = load || retrig_idle;
    assign cnt_inc     = cnt + 1'b1;
    assign cnt_dec     = cnt - 1'b1;
    assign at_end      = (cnt == end_val);

    cnt_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (presc_clear),
        .presc (presc),
        .tick  (tick)
    );

    // Priority: load > RETRIG idle clear > step. Reset is applied in the register block.
    always_comb begin
        cnt_nxt = cnt;
        tc_nxt  = 1'b0;
        ovf_set = 1'b0;
        if (load) begin
            cnt_nxt = load_val;
        end else if (retrig_idle) begin
            cnt_nxt = '0;
        end else if (tick) begin
            case (mode)
                MODE_SAT: begin
                    if (up) begin
                        if (cnt >= end_val) begin
                            cnt_nxt = end_val;
                            ovf_set = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                            tc_nxt  = (cnt_inc == end_val);
                        end
                    end else begin
                        if (cnt == '0) begin
                            ovf_set = 1'b1;
                        end else begin
                            cnt_nxt = cnt_dec;
                            tc_nxt  = (cnt_dec == '0);
                        end
                    end
                end
                MODE_RETRIG: begin
                    // Counts up to end_val once per enabled run, then holds without further pulses.
                    if (cnt < end_val) begin
                        cnt_nxt = cnt_inc;
                        tc_nxt  = (cnt_inc == end_val);
                    end
                end
                default: begin
                    if (up) begin
                        if (cnt >= end_val) begin
                            cnt_nxt = '0;
                            tc_nxt  = 1'b1;
                            ovf_set = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        if (cnt == '0) begin
                            cnt_nxt = end_val;
                            tc_nxt  = 1'b1;
                            ovf_set = 1'b1;
                        end else begin
                            cnt_nxt = cnt_dec;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            tc  <= tc_nxt;
            // A new overflow event outranks a simultaneous clear.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnt_updown_mod.sv
// Self-checking bench for cnt_updown_mod: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_cnt_updown_mod;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;
    localparam int CMAX    = (1 << WIDTH) - 1;
    localparam int PMOD    = 1 << PRESC_W;

    logic               clk;
    logic               rst;
    logic               en;
    logic               up;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   end_val;
    logic [PRESC_W-1:0] presc;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               clr_ovf;
    logic [WIDTH-1:0]   cnt;
    logic               at_end;
    logic               tc;
    logic               ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state, plain integers.
    int m_cnt = 0;
    int m_pc  = 0;
    int m_tc  = 0;
    int m_ovf = 0;

    logic [WIDTH-1:0] exp_q[$];

    cnt_updown_mod #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .end_val  (end_val),
        .presc    (presc),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
        .cnt      (cnt),
        .at_end   (at_end),
        .tc       (tc),
        .ovf      (ovf)
    );

    // Clock / reset block: falling edges at 10, 20, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one falling edge using the inputs currently applied.
    task automatic model_edge();
        int tick;
        int nc;
        int ntc;
        int set;
        int e;
        if (!rst) begin
            m_cnt = 0; m_pc = 0; m_tc = 0; m_ovf = 0;
            return;
        end
        e    = int'(end_val);
        tick = (en && m_pc == int'(presc)) ? 1 : 0;
        nc   = m_cnt;
        ntc  = 0;
        set  = 0;
        if (load) begin
            nc = int'(load_val);
        end else if (mode == 2 && !en) begin
            nc = 0;
        end else if (tick == 1) begin
            if (mode == 2) begin
                if (m_cnt < e) begin nc = m_cnt + 1; ntc = (nc == e) ? 1 : 0; end
            end else if (mode == 1) begin
                if (up) begin
                    if (m_cnt >= e) begin nc = e; set = 1; end
                    else begin nc = m_cnt + 1; ntc = (nc == e) ? 1 : 0; end
                end else begin
                    if (m_cnt == 0) set = 1;
                    else begin nc = m_cnt - 1; ntc = (nc == 0) ? 1 : 0; end
                end
            end else begin
                if (up) begin
                    if (m_cnt >= e) begin nc = 0; ntc = 1; set = 1; end
                    else nc = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin nc = e; ntc = 1; set = 1; end
                    else nc = m_cnt - 1;
                end
            end
        end
        if (load || (mode == 2 && !en)) m_pc = 0;
        else if (en) m_pc = (tick == 1) ? 0 : (m_pc + 1) % PMOD;
        m_cnt = nc % (CMAX + 1);
        m_tc  = ntc;
        if (set == 1) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    // Driver: one falling edge, outputs settled 1 time unit later.
    task automatic clock_edge();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic u, input logic e,
                         input int ev, input int p);
        mode = m; up = u; en = e;
        end_val = WIDTH'(ev);
        presc = PRESC_W'(p);
        load = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 1'b1; load_val = 8'd99; en = 1'b1;
        for (int i = 0; i < 2; i++) clock_edge();
        checks++;
        if (cnt !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: cnt=%0d tc=%0b ovf=%0b want cnt=0 tc=0 ovf=0", cnt, tc, ovf);
        end
        rst = 1'b1;
    endtask

    task automatic test_wrap_up();
        drive(2'd0, 1'b1, 1'b1, 5, 0);
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        for (int i = 0; i < 7; i++) begin
            logic [WIDTH-1:0] exp_c;
            exp_c = exp_q.pop_front();
            clock_edge();
            checks++;
            if (cnt !== exp_c || tc !== (i == 5)) begin
                errors++;
                $display("FAIL wrap_up edge %0d: cnt=%0d tc=%0b want cnt=%0d tc=%0b", i, cnt, tc, exp_c, (i == 5));
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up ovf: got %0b want 1", ovf);
        end
    endtask

    task automatic test_down_presc();
        drive(2'd0, 1'b0, 1'b1, 9, 2);
        load = 1'b1; load_val = 8'd1; clr_ovf = 1'b1;
        clock_edge();
        checks++;
        if (cnt !== 8'd1 || ovf !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL down_load: cnt=%0d ovf=%0b tc=%0b want cnt=1 ovf=0 tc=0", cnt, ovf, tc);
        end
        load = 1'b0; clr_ovf = 1'b0;
        exp_q = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd9};
        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] exp_c;
            exp_c = exp_q.pop_front();
            clock_edge();
            checks++;
            if (cnt !== exp_c || tc !== (i == 5)) begin
                errors++;
                $display("FAIL down_presc edge %0d: cnt=%0d tc=%0b want cnt=%0d tc=%0b", i, cnt, tc, exp_c, (i == 5));
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL down_presc ovf: got %0b want 1", ovf);
        end
    endtask

    task automatic test_saturate();
        drive(2'd1, 1'b1, 1'b1, 3, 0);
        load = 1'b1; load_val = 8'd0; clr_ovf = 1'b1;
        clock_edge();
        load = 1'b0; clr_ovf = 1'b0;
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        for (int i = 0; i < 5; i++) begin
            logic [WIDTH-1:0] exp_c;
            exp_c = exp_q.pop_front();
            clock_edge();
            checks++;
            if (cnt !== exp_c || tc !== (i == 2) || ovf !== (i >= 3)) begin
                errors++;
                $display("FAIL saturate edge %0d: cnt=%0d tc=%0b ovf=%0b want cnt=%0d tc=%0b ovf=%0b",
                         i, cnt, tc, ovf, exp_c, (i == 2), (i >= 3));
            end
        end
        clr_ovf = 1'b1;
        clock_edge();
        checks++;
        if (ovf !== 1'b1 || cnt !== 8'd3 || tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_set_wins: ovf=%0b cnt=%0d tc=%0b want ovf=1 cnt=3 tc=0", ovf, cnt, tc);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_retrig();
        logic en_pat [10];
        en_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        drive(2'd2, 1'b0, 1'b0, 4, 0);
        clr_ovf = 1'b1;
        clock_edge();
        clr_ovf = 1'b0;
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
        for (int i = 0; i < 10; i++) begin
            logic [WIDTH-1:0] exp_c;
            exp_c = exp_q.pop_front();
            en = en_pat[i];
            clock_edge();
            checks++;
            if (cnt !== exp_c || tc !== (i == 7) || ovf !== 1'b0) begin
                errors++;
                $display("FAIL retrig edge %0d: cnt=%0d tc=%0b ovf=%0b want cnt=%0d tc=%0b ovf=0",
                         i, cnt, tc, ovf, exp_c, (i == 7));
            end
        end
    endtask

    task automatic test_load_priority();
        drive(2'd0, 1'b1, 1'b1, 10, 0);
        load = 1'b1; load_val = 8'd200;
        clock_edge();
        checks++;
        if (cnt !== 8'd200 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_prio: cnt=%0d tc=%0b want cnt=200 tc=0", cnt, tc);
        end
        load = 1'b0;
        clock_edge();
        checks++;
        if (cnt !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL load_wrap: cnt=%0d tc=%0b ovf=%0b want cnt=0 tc=1 ovf=1", cnt, tc, ovf);
        end
        rst = 1'b0; load = 1'b1; load_val = 8'd77;
        clock_edge();
        checks++;
        if (cnt !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_load: cnt=%0d tc=%0b ovf=%0b want cnt=0 tc=0 ovf=0", cnt, tc, ovf);
        end
        rst = 1'b1; load = 1'b0;
    endtask

    task automatic test_end_zero();
        drive(2'd0, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            clock_edge();
            checks++;
            if (cnt !== 8'd0 || tc !== 1'b1 || at_end !== 1'b1) begin
                errors++;
                $display("FAIL end_zero edge %0d: cnt=%0d tc=%0b at_end=%0b want cnt=0 tc=1 at_end=1", i, cnt, tc, at_end);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: end_val = 8'd0;
                    1: end_val = 8'hFF;
                    2: end_val = 8'($urandom_range(1, 12));
                    default: end_val = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 29) == 0) presc = 4'($urandom_range(0, 3));
            en       = ($urandom_range(0, 9) != 0);
            up       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom);
            clr_ovf  = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 79) != 0);
            clock_edge();
            checks++;
            if (int'(cnt) != m_cnt || int'(tc) != m_tc || int'(ovf) != m_ovf ||
                at_end !== (m_cnt == int'(end_val))) begin
                errors++;
                $display("FAIL random step %0d: cnt=%0d tc=%0b ovf=%0b at_end=%0b want cnt=%0d tc=%0d ovf=%0d at_end=%0b",
                         i, cnt, tc, ovf, at_end, m_cnt, m_tc, m_ovf, (m_cnt == int'(end_val)));
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; mode = 2'd0; end_val = '0;
        presc = '0; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
        test_reset();
        test_wrap_up();
        test_down_presc();
        test_saturate();
        test_retrig();
        test_load_priority();
        test_end_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
